mul_add_seq: RTL and testbench

Sequential shift-add multiply-accumulate unit that reconstructs a dividend from a division result: dividend = quotient × divisor + remainder. It is the inverse of the N-bit divider and uses the same parameter pair, so the two blocks can be chained for round-trip checking and used as the multiply path of the FP package. Each operation is started with a handshake, takes a fixed number of cycles, processes one divisor bit per cycle, and also flags remainder-validity errors.

---
 rtl/mul_add_seq.sv | 85 ++++++++
 tb/tb_mul_add_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// Sequential shift-add multiply-accumulate: dividend = quotient * divisor + remainder.
// Processes one multiplier bit per cycle and flags remainder >= divisor.
module mul_add_seq #(
    parameter int DIVIDEND = 16,
    parameter int DIVISOR  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [DIVIDEND-1:0]          quotient,
    input  logic [DIVISOR-1:0]           divisor,
    input  logic [DIVISOR-1:0]           remainder,
    output logic                         busy,
    output logic                         done,
    output logic [DIVIDEND+DIVISOR-1:0]  dividend,
    output logic                         rem_err
);
    localparam int RW = DIVIDEND + DIVISOR;
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [RW-1:0]       acc;
    logic [RW-1:0]       mcand;
    logic [DIVISOR-1:0]  mplier;
    logic [CW-1:0]       cnt;
    logic [DIVISOR-1:0]  rem_q;
    logic [DIVISOR-1:0]  div_q;

    logic                accept;
    logic                last;
    logic [RW-1:0]       sum;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(DIVISOR - 1));
    // Sum of this iteration; on the last RUN edge it is the final result.
    assign sum    = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dividend <= '0;
            rem_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                acc    <= {{DIVIDEND{1'b0}}, remainder};
                mcand  <= {{DIVISOR{1'b0}}, quotient};
                mplier <= divisor;
                rem_q  <= remainder;
                div_q  <= divisor;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        acc    <= sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            dividend <= sum;
                            rem_err  <= (rem_q >= div_q);
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mul_add_seq.sv
// Directed and round-trip checks for mul_add_seq (DIVIDEND=16, DIVISOR=8).
module tb_mul_add_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] quotient = '0;
    logic [7:0]  divisor = '0;
    logic [7:0]  remainder = '0;
    logic        busy, done, rem_err;
    logic [23:0] res;

    int checks = 0;
    int errors = 0;

    mul_add_seq #(.DIVIDEND(16), .DIVISOR(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .quotient(quotient), .divisor(divisor), .remainder(remainder),
        .busy(busy), .done(done), .dividend(res), .rem_err(rem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one operation, scramble inputs after acceptance, check the handshake and result.
    task automatic do_op(input string tag, input logic [15:0] q, input logic [7:0] d,
                         input logic [7:0] r, input logic [23:0] exp_res, input logic exp_err);
        @(negedge clk);
        quotient = q; divisor = d; remainder = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        quotient = 16'($urandom); divisor = 8'($urandom); remainder = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            if (i < 7) @(negedge clk);
        end
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_res"}, {8'd0, res}, {8'd0, exp_res});
        chk({tag, "_err"}, {31'd0, rem_err}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_res_hold"}, {8'd0, res}, {8'd0, exp_res});
    endtask

    initial begin
        logic [23:0] dvd;
        logic [7:0]  dvs;

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", {8'd0, res}, 32'd0);
        chk("rst_err", {31'd0, rem_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 0x1234*0x56 = 0x61D78, +0x2B
        do_op("basic", 16'h1234, 8'h56, 8'h2B, 24'h061DA3, 1'b0);
        do_op("max", 16'hFFFF, 8'hFF, 8'hFE, 24'hFEFFFF, 1'b0);
        do_op("div0", 16'hABCD, 8'h00, 8'h07, 24'h000007, 1'b1);
        do_op("remeq", 16'h0002, 8'h05, 8'h05, 24'h00000F, 1'b1);

        // Back-to-back: A = 3*5+2, B = 10*10+0 accepted in A's done cycle.
        @(negedge clk);
        quotient = 16'd3; divisor = 8'd5; remainder = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("a_done", {31'd0, done}, 32'd1);
        chk("a_res", {8'd0, res}, 32'd17);
        quotient = 16'd10; divisor = 8'd10; remainder = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b_accept_busy", {31'd0, busy}, 32'd1);
        chk("b_accept_nodone", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        quotient = 16'd7; divisor = 8'd7; remainder = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_nodone_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("b_done", {31'd0, done}, 32'd1);
        chk("b_res", {8'd0, res}, 32'd100);
        chk("b_err", {31'd0, rem_err}, 32'd0);
        @(negedge clk);
        chk("b_ignored_busy", {31'd0, busy}, 32'd0);
        chk("b_ignored_done", {31'd0, done}, 32'd0);

        // Reset during RUN cycle 4.
        @(negedge clk);
        quotient = 16'h00FF; divisor = 8'h11; remainder = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_res", {8'd0, res}, 32'd0);
        chk("arst_err", {31'd0, rem_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("arst_no_done", {31'd0, done}, 32'd0);
        end
        do_op("post_rst", 16'h00FF, 8'h11, 8'h03, 24'h0010F2, 1'b0);

        // Round trip through a behavioural divider.
        for (int i = 0; i < 20; i++) begin
            dvs = 8'($urandom_range(1, 255));
            dvd = 24'($urandom % ({8'd0, dvs} << 16));
            do_op("rtrip", 16'(dvd / {16'd0, dvs}), dvs, 8'(dvd % {16'd0, dvs}), dvd, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
